// File: rtl/vga_timing_engine_pkg.sv
// Shared definitions for the VGA timing engine.
// Provides standard mode timings, axis total and sync-window helpers, and the NCO
// increment calculation. There are no ports; other files pull it in with an import.
package vga_timing_engine_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    // Standard modes. The H fields are in pixels and the V fields are in lines.
    localparam axis_timing_t Vga640x480H  = '{active: 640,  fp: 16, sync: 96,  bp: 48};
    localparam axis_timing_t Vga640x480V  = '{active: 480,  fp: 10, sync: 2,   bp: 33};
    localparam axis_timing_t Vga800x600H  = '{active: 800,  fp: 40, sync: 128, bp: 88};
    localparam axis_timing_t Vga800x600V  = '{active: 600,  fp: 1,  sync: 4,   bp: 23};
    localparam axis_timing_t Vga1024x768H = '{active: 1024, fp: 24, sync: 136, bp: 160};
    localparam axis_timing_t Vga1024x768V = '{active: 768,  fp: 3,  sync: 6,   bp: 29};

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
        return active + fp;
    endfunction

    function automatic int unsigned sync_end(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync);
        return active + fp + sync;
    endfunction

    // round(2^acc_w * pix / clk), computed in 64 bits.
    function automatic longint unsigned nco_inc(input longint unsigned clk_freq,
                                                input longint unsigned pix_freq,
                                                input int unsigned acc_w);
        longint unsigned num;
        num = (pix_freq << acc_w) + (clk_freq >> 1);
        return num / clk_freq;
    endfunction

endpackage

// File: rtl/vga_timing_engine_nco.sv
// Fractional pixel-rate strobe generator (phase accumulator with a carry output).
// Ports:
//   clk    : system clock
//   reset  : synchronous reset, active-low; clears the accumulator
//   enable : 0 freezes the accumulator and suppresses the strobe
//   tick   : combinational one-clk strobe, high on accumulator carry
//            (tied to enable at full rate)
module vga_pixel_nco
    import vga_timing_engine_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned PIX_FREQ = 25175000,
    parameter int unsigned ACC_W    = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    if (PIX_FREQ >= CLK_FREQ) begin : g_full_rate
        logic unused_full_rate;
        assign unused_full_rate = ^{clk, reset};
        assign tick = enable;
    end else begin : g_acc
        localparam logic [ACC_W-1:0] Inc = ACC_W'(nco_inc(CLK_FREQ, PIX_FREQ, ACC_W));

        logic [ACC_W-1:0] acc_q;
        logic [ACC_W:0]   sum;

        assign sum  = {1'b0, acc_q} + {1'b0, Inc};
        assign tick = enable & sum[ACC_W];

        always_ff @(posedge clk) begin
            if (!reset) begin
                acc_q <= '0;
            end else if (enable) begin
                acc_q <= sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/vga_timing_engine.sv
// Raster timing generator. An NCO-paced horizontal/vertical counter pair drives registered
// decode of sync, data-enable, scaled coordinates, line/frame strobes and a look-ahead fetch
// position.
// Ports:
//   clk, reset (synchronous, active-low), enable (0 freezes everything; strobes forced to 0)
//   pixel_tick              : one-clk strobe per pixel advance
//   h_sync, v_sync          : syncs, active level H_SYNC_POL / V_SYNC_POL
//   de, h_pixel, v_pixel    : active-area flag and scaled coordinates (0 in blanking)
//   line_start, frame_start : strobes coincident with the tick that enters h_pos 0 (and v_pos 0)
//   fetch_valid, fetch_x, fetch_y : decode of the position LOOKAHEAD pixels ahead
// Decoded outputs trail the counters by one clk.
module vga_timing_engine
    import vga_timing_engine_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned PIX_FREQ   = 25175000,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned H_ACTIVE   = Vga640x480H.active,
    parameter int unsigned H_FP       = Vga640x480H.fp,
    parameter int unsigned H_SYNC     = Vga640x480H.sync,
    parameter int unsigned H_BP       = Vga640x480H.bp,
    parameter int unsigned V_ACTIVE   = Vga640x480V.active,
    parameter int unsigned V_FP       = Vga640x480V.fp,
    parameter int unsigned V_SYNC     = Vga640x480V.sync,
    parameter int unsigned V_BP       = Vga640x480V.bp,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0,
    parameter int unsigned H_SHIFT    = 0,
    parameter int unsigned V_SHIFT    = 0,
    parameter int unsigned LOOKAHEAD  = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    output logic                                  pixel_tick,
    output logic                                  h_sync,
    output logic                                  v_sync,
    output logic                                  de,
    output logic [$clog2(H_ACTIVE)-H_SHIFT-1:0]   h_pixel,
    output logic [$clog2(V_ACTIVE)-V_SHIFT-1:0]   v_pixel,
    output logic                                  line_start,
    output logic                                  frame_start,
    output logic                                  fetch_valid,
    output logic [$clog2(H_ACTIVE)-H_SHIFT-1:0]   fetch_x,
    output logic [$clog2(V_ACTIVE)-V_SHIFT-1:0]   fetch_y
);

    localparam int unsigned HTotal = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned VTotal = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HCW    = $clog2(HTotal);
    localparam int unsigned VCW    = $clog2(VTotal);
    localparam int unsigned HPW    = $clog2(H_ACTIVE) - H_SHIFT;
    localparam int unsigned VPW    = $clog2(V_ACTIVE) - V_SHIFT;
    localparam int unsigned HSyncStart = sync_start(H_ACTIVE, H_FP);
    localparam int unsigned HSyncEnd   = sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam int unsigned VSyncStart = sync_start(V_ACTIVE, V_FP);
    localparam int unsigned VSyncEnd   = sync_end(V_ACTIVE, V_FP, V_SYNC);
    localparam logic [HCW-1:0] HLast = HCW'(HTotal - 1);
    localparam logic [VCW-1:0] VLast = VCW'(VTotal - 1);

    logic           tick;
    logic           tick_q;
    logic [HCW-1:0] h_pos_q, h_pos_d;
    logic [VCW-1:0] v_pos_q, v_pos_d;

    vga_pixel_nco #(
        .CLK_FREQ (CLK_FREQ),
        .PIX_FREQ (PIX_FREQ),
        .ACC_W    (ACC_W)
    ) u_nco (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    always_comb begin
        h_pos_d = h_pos_q;
        v_pos_d = v_pos_q;
        if (tick) begin
            if (h_pos_q == HLast) begin
                h_pos_d = '0;
                v_pos_d = (v_pos_q == VLast) ? '0 : v_pos_q + 1'b1;
            end else begin
                h_pos_d = h_pos_q + 1'b1;
            end
        end
    end

    // Look-ahead position. LOOKAHEAD never exceeds the blanking width, so one wrap suffices.
    logic [HCW:0]   la_sum;
    logic [HCW-1:0] la_h;
    logic [VCW-1:0] la_v;

    always_comb begin
        la_sum = {1'b0, h_pos_q} + (HCW+1)'(LOOKAHEAD);
        la_h   = la_sum[HCW-1:0];
        la_v   = v_pos_q;
        if (32'(la_sum) >= HTotal) begin
            la_h = HCW'(la_sum - (HCW+1)'(HTotal));
            la_v = (v_pos_q == VLast) ? '0 : v_pos_q + 1'b1;
        end
    end

    logic           de_d, fetch_valid_d, h_win, v_win, strobe;
    logic [HPW-1:0] h_pixel_d, fetch_x_d;
    logic [VPW-1:0] v_pixel_d, fetch_y_d;

    always_comb begin
        de_d          = (32'(h_pos_q) < H_ACTIVE) && (32'(v_pos_q) < V_ACTIVE);
        fetch_valid_d = (32'(la_h) < H_ACTIVE) && (32'(la_v) < V_ACTIVE);
        h_pixel_d     = de_d ? HPW'(h_pos_q >> H_SHIFT) : '0;
        v_pixel_d     = de_d ? VPW'(v_pos_q >> V_SHIFT) : '0;
        fetch_x_d     = fetch_valid_d ? HPW'(la_h >> H_SHIFT) : '0;
        fetch_y_d     = fetch_valid_d ? VPW'(la_v >> V_SHIFT) : '0;
        h_win         = (32'(h_pos_q) >= HSyncStart) && (32'(h_pos_q) < HSyncEnd);
        v_win         = (32'(v_pos_q) >= VSyncStart) && (32'(v_pos_q) < VSyncEnd);
        // tick_q marks the clk after the counters moved; gating with enable drops strobes
        // as soon as the engine is frozen.
        strobe        = tick_q & enable;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_q      <= 1'b0;
            h_pos_q     <= '0;
            v_pos_q     <= '0;
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            h_sync      <= ~H_SYNC_POL;
            v_sync      <= ~V_SYNC_POL;
            de          <= 1'b0;
            h_pixel     <= '0;
            v_pixel     <= '0;
            fetch_valid <= 1'b0;
            fetch_x     <= '0;
            fetch_y     <= '0;
        end else begin
            tick_q      <= tick;
            h_pos_q     <= h_pos_d;
            v_pos_q     <= v_pos_d;
            pixel_tick  <= strobe;
            line_start  <= strobe && (h_pos_q == '0);
            frame_start <= strobe && (h_pos_q == '0) && (v_pos_q == '0);
            h_sync      <= h_win ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync      <= v_win ? V_SYNC_POL : ~V_SYNC_POL;
            de          <= de_d;
            h_pixel     <= h_pixel_d;
            v_pixel     <= v_pixel_d;
            fetch_valid <= fetch_valid_d;
            fetch_x     <= fetch_x_d;
            fetch_y     <= fetch_y_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine. It runs three instances in a small 14x7 mode:
//   u_a: full rate, active-low syncs, no scaling, LOOKAHEAD=2
//   u_b: full rate, active-high syncs, 2x downscale, LOOKAHEAD=0
//   u_c: 30/100 fractional pixel rate
module tb_vga_timing_engine;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;
    always #5 clk = ~clk;

    logic       a_tick, a_hs, a_vs, a_de, a_ls, a_fs, a_fv;
    logic [2:0] a_hp, a_fx;
    logic [1:0] a_vp, a_fy;
    logic       b_tick, b_hs, b_vs, b_de, b_ls, b_fs, b_fv;
    logic [1:0] b_hp, b_fx;
    logic [0:0] b_vp, b_fy;
    logic       c_tick, c_hs, c_vs, c_de, c_ls, c_fs, c_fv;
    logic [2:0] c_hp, c_fx;
    logic [1:0] c_vp, c_fy;

    vga_timing_engine #(
        .CLK_FREQ(25), .PIX_FREQ(25), .ACC_W(32),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .H_SHIFT(0), .V_SHIFT(0), .LOOKAHEAD(2)
    ) u_a (
        .clk(clk), .reset(reset), .enable(enable), .pixel_tick(a_tick),
        .h_sync(a_hs), .v_sync(a_vs), .de(a_de), .h_pixel(a_hp), .v_pixel(a_vp),
        .line_start(a_ls), .frame_start(a_fs), .fetch_valid(a_fv),
        .fetch_x(a_fx), .fetch_y(a_fy)
    );

    vga_timing_engine #(
        .CLK_FREQ(25), .PIX_FREQ(25), .ACC_W(32),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .H_SHIFT(1), .V_SHIFT(1), .LOOKAHEAD(0)
    ) u_b (
        .clk(clk), .reset(reset), .enable(enable), .pixel_tick(b_tick),
        .h_sync(b_hs), .v_sync(b_vs), .de(b_de), .h_pixel(b_hp), .v_pixel(b_vp),
        .line_start(b_ls), .frame_start(b_fs), .fetch_valid(b_fv),
        .fetch_x(b_fx), .fetch_y(b_fy)
    );

    vga_timing_engine #(
        .CLK_FREQ(100), .PIX_FREQ(30), .ACC_W(32),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .H_SHIFT(0), .V_SHIFT(0), .LOOKAHEAD(0)
    ) u_c (
        .clk(clk), .reset(reset), .enable(enable), .pixel_tick(c_tick),
        .h_sync(c_hs), .v_sync(c_vs), .de(c_de), .h_pixel(c_hp), .v_pixel(c_vp),
        .line_start(c_ls), .frame_start(c_fs), .fetch_valid(c_fv),
        .fetch_x(c_fx), .fetch_y(c_fy)
    );

    int total = 0;
    int bad = 0;
    int pos;
    int c_ticks, c_win, c_adj;
    logic c_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("a_tick_rst", 32'(a_tick), 32'd0);
        check("a_hs_rst",   32'(a_hs),   32'd1);
        check("a_vs_rst",   32'(a_vs),   32'd1);
        check("a_de_rst",   32'(a_de),   32'd0);
        check("a_hp_rst",   32'(a_hp),   32'd0);
        check("a_vp_rst",   32'(a_vp),   32'd0);
        check("a_ls_rst",   32'(a_ls),   32'd0);
        check("a_fs_rst",   32'(a_fs),   32'd0);
        check("a_fv_rst",   32'(a_fv),   32'd0);
        check("a_fx_rst",   32'(a_fx),   32'd0);
        check("a_fy_rst",   32'(a_fy),   32'd0);
        check("b_hs_rst",   32'(b_hs),   32'd0);
        check("b_vs_rst",   32'(b_vs),   32'd0);
        check("b_de_rst",   32'(b_de),   32'd0);
        check("c_tick_rst", 32'(c_tick), 32'd0);
    endtask

    // Expected outputs of u_a/u_b when they show raster position p (pixel index since reset).
    task automatic check_pos(input int p, input logic tk);
        int h, v, lh, lv;
        logic de_e, fv_e, ls_e;
        h = p % 14;
        v = (p / 14) % 7;
        lh = h + 2;
        lv = v;
        if (lh >= 14) begin
            lh = lh - 14;
            lv = (v + 1) % 7;
        end
        de_e = (h < 8) && (v < 4);
        fv_e = (lh < 8) && (lv < 4);
        ls_e = tk && (h == 0);
        check("a_tick", 32'(a_tick), 32'(tk));
        check("a_hs",   32'(a_hs),   32'(!(h >= 10 && h < 12)));
        check("a_vs",   32'(a_vs),   32'(v != 5));
        check("a_de",   32'(a_de),   32'(de_e));
        check("a_hp",   32'(a_hp),   de_e ? 32'(h) : 32'd0);
        check("a_vp",   32'(a_vp),   de_e ? 32'(v) : 32'd0);
        check("a_ls",   32'(a_ls),   32'(ls_e));
        check("a_fs",   32'(a_fs),   32'(ls_e && v == 0));
        check("a_fv",   32'(a_fv),   32'(fv_e));
        check("a_fx",   32'(a_fx),   fv_e ? 32'(lh) : 32'd0);
        check("a_fy",   32'(a_fy),   fv_e ? 32'(lv) : 32'd0);
        check("b_tick", 32'(b_tick), 32'(tk));
        check("b_hs",   32'(b_hs),   32'(h >= 10 && h < 12));
        check("b_vs",   32'(b_vs),   32'(v == 5));
        check("b_de",   32'(b_de),   32'(de_e));
        check("b_hp",   32'(b_hp),   de_e ? 32'(h / 2) : 32'd0);
        check("b_vp",   32'(b_vp),   de_e ? 32'(v / 2) : 32'd0);
        check("b_ls",   32'(b_ls),   32'(ls_e));
        check("b_fs",   32'(b_fs),   32'(ls_e && v == 0));
        check("b_fv",   32'(b_fv),   32'(de_e));
        check("b_fx",   32'(b_fx),   de_e ? 32'(h / 2) : 32'd0);
        check("b_fy",   32'(b_fy),   de_e ? 32'(v / 2) : 32'd0);
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        check_reset();

        // Free run from reset. u_c: INC=round(0.3*2^32), so samples 0..10002 carry
        // floor(10002*0.3)=3000 ticks and samples 100..109 carry 3.
        reset   = 1'b1;
        c_ticks = 0;
        c_win   = 0;
        c_adj   = 0;
        c_prev  = 1'b0;
        for (int k = 0; k < 10003; k++) begin
            step();
            check_pos(k, k != 0);
            if (c_tick) begin
                c_ticks++;
                if (k >= 100 && k < 110) c_win++;
                if (c_prev) c_adj++;
            end
            c_prev = c_tick;
        end
        check("c_tick_count", 32'(c_ticks), 32'd3000);
        check("c_tick_window", 32'(c_win), 32'd3);
        check("c_tick_adjacent", 32'(c_adj), 32'd0);
        pos = 10002;

        // Freeze mid-line: counters already sit one pixel ahead of the displayed one.
        while (pos % 14 != 3) begin
            step();
            pos++;
            check_pos(pos, 1'b1);
        end
        enable = 1'b0;
        step();
        pos++;
        check_pos(pos, 1'b0);
        check("c_tick_frozen", 32'(c_tick), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_pos(pos, 1'b0);
            check("c_tick_frozen", 32'(c_tick), 32'd0);
        end
        enable = 1'b1;
        step();
        check_pos(pos, 1'b0);
        for (int i = 0; i < 120; i++) begin
            step();
            pos++;
            check_pos(pos, 1'b1);
        end

        // Reset in the middle of a frame.
        while ((pos / 14) % 7 != 2) begin
            step();
            pos++;
            check_pos(pos, 1'b1);
        end
        reset = 1'b0;
        step();
        check_reset();
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check_pos(k, k != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
